updown_counter_param: RTL and testbench

//   Parametrised synchronous up/down binary counter, the next generation of the 3-bit
//   T-flip-flop up/down counter. Adds generic width, programmable modulus, enable,

---
 rtl/updown_counter_param.sv | 90 +++++++++
 tb/tb_updown_counter_param.sv | 139 +++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, parallel load, wrap/saturate mode,
// terminal-count, one-cycle wrap pulse and sticky overflow flag.
module updown_counter_param #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MOD_MAX = (1 << WIDTH) - 1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_en,
  input  logic             in_m,
  input  logic             in_sat,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_clr_ovf,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;
  logic             limit_evt;

  assign at_max  = (q_q == MaxVal);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    limit_evt = 1'b0;
    if (in_load) begin
      q_d = (in_d > MaxVal) ? MaxVal : in_d;
    end else if (in_en) begin
      if (in_m) begin
        if (at_max) begin
          limit_evt = 1'b1;
          if (!in_sat) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          limit_evt = 1'b1;
          if (!in_sat) begin
            q_d    = MaxVal;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // A wrap or limit in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (limit_evt) begin
      ovf_d = 1'b1;
    end else if (in_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_q    = q_q;
  assign o_wrap = wrap_q;
  assign o_ovf  = ovf_q;
  assign o_tc   = in_en & ~in_load & ((in_m & at_max) | (~in_m & at_zero));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a full-range (WIDTH=3) and a modulus-5 instance driven in
// parallel, checked against a behavioural model through an expected-value queue.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, m = 1'b0, sat = 1'b0, load = 1'b0, clr = 1'b0;
  logic [2:0] d = '0;

  logic [2:0] q7, q5;
  logic       tc7, tc5, w7, w5, o7, o5;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(3)) dut7 (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_m(m), .in_sat(sat), .in_load(load),
    .in_d(d), .in_clr_ovf(clr), .o_q(q7), .o_tc(tc7), .o_wrap(w7), .o_ovf(o7)
  );

  updown_counter_param #(.WIDTH(3), .MOD_MAX(5)) dut5 (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_m(m), .in_sat(sat), .in_load(load),
    .in_d(d), .in_clr_ovf(clr), .o_q(q5), .o_tc(tc5), .o_wrap(w5), .o_ovf(o5)
  );

  typedef struct packed {
    int q;
    bit w;
    bit o;
  } st_t;

  st_t st7 = '0, st5 = '0;
  st_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Count in plain integers and detect leaving the range 0..maxv.
  function automatic st_t model(input int maxv, input st_t cur, input bit r, ld, input int dv,
                                input bit e, mm, s, c);
    st_t nxt;
    int  nq;
    bit  ev;
    nxt = cur;
    ev  = 1'b0;
    nxt.w = 1'b0;
    if (r) begin
      nxt = '0;
    end else begin
      if (ld) begin
        nxt.q = (dv > maxv) ? maxv : dv;
      end else if (e) begin
        nq = mm ? cur.q + 1 : cur.q - 1;
        if (nq > maxv || nq < 0) begin
          ev = 1'b1;
          if (s) nq = cur.q;
          else begin
            nq    = mm ? 0 : maxv;
            nxt.w = 1'b1;
          end
        end
        nxt.q = nq;
      end
      if (ev) nxt.o = 1'b1;
      else if (c) nxt.o = 1'b0;
    end
    return nxt;
  endfunction

  task automatic step(input bit r, ld, input int dv, input bit e, mm, s, c);
    st_t got;
    @(negedge clk);
    rst = r; load = ld; d = 3'(dv); en = e; m = mm; sat = s; clr = c;
    #1;
    check_eq("tc7", 32'(tc7), 32'(e & ~ld & (mm ? st7.q == 7 : st7.q == 0)));
    check_eq("tc5", 32'(tc5), 32'(e & ~ld & (mm ? st5.q == 5 : st5.q == 0)));
    st7 = model(7, st7, r, ld, dv, e, mm, s, c);
    st5 = model(5, st5, r, ld, dv, e, mm, s, c);
    sb.push_back(st7);
    sb.push_back(st5);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("q7", 32'(q7), 32'(got.q));
    check_eq("wrap7", 32'(w7), 32'(got.w));
    check_eq("ovf7", 32'(o7), 32'(got.o));
    got = sb.pop_front();
    check_eq("q5", 32'(q5), 32'(got.q));
    check_eq("wrap5", 32'(w5), 32'(got.w));
    check_eq("ovf5", 32'(o5), 32'(got.o));
  endtask

  initial begin
    // Up-count wrap
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1, 1, 0, 0);
    // Down-count wrap from zero, then hold with enable low
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Saturate at top, then clear overflow
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 1);
    // Saturate at bottom
    step(0, 1, 1, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // Modulus check and clamped load
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (7) step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0);
    // Load wins over count; clear coincident with wrap keeps ovf set
    step(0, 1, 3, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 1, 1, 0, 1);
    // Reset beats load mid-count
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 5, 1, 1, 0, 0);
    // Mixed random traffic
    repeat (80) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 7),
           ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
